// File: rtl/lagd_sched_pkg.sv
// Shared types and sizing for the Ising job scheduler.
// NUM_ISING_CORES sets the default core count (4 when the macro is not defined).
`ifndef NUM_ISING_CORES
`define NUM_ISING_CORES 4
`endif

package lagd_sched_pkg;

    localparam int NumCoresDef = `NUM_ISING_CORES;
    localparam int JobIdW      = 8;
    localparam int CoreIdxW    = (NumCoresDef > 1) ? $clog2(NumCoresDef) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } core_state_e;

    typedef struct packed {
        logic [JobIdW-1:0]   id;
        logic [CoreIdxW-1:0] core;
        logic                timeout;
    } cpl_t;

endpackage

// File: rtl/ising_sched_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward, one-hot grant plus index.
// The pointer moves to the core after the granted one whenever en_i is high.
module ising_sched_rr_arb #(
    parameter int N    = 4,
    parameter int IdxW = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            en_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            vld_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_q) + i) % N;
            if (!vld_o && req_i[IdxW'(j)]) begin
                vld_o               = 1'b1;
                gnt_o[IdxW'(j)]     = 1'b1;
                idx_o               = IdxW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && vld_o) begin
            ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ising_job_scheduler.sv
// Ising job scheduler: dispatches host jobs onto Ising cores and returns one completion record per job.
// Defining LAGD_SCHED_TIMEOUT_EN adds a per-core run timeout that force-stops a core.
module ising_job_scheduler
    import lagd_sched_pkg::*;
#(
    parameter int NumCores      = NumCoresDef,
    parameter int JobIdWidth    = 8,
    parameter int CfgWidth      = 32,
    parameter int TimeoutCycles = 65535
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        job_valid_i,
    output logic                        job_ready_o,
    input  logic [JobIdWidth-1:0]       job_id_i,
    input  logic [CfgWidth-1:0]         job_cfg_i,
    input  logic [NumCores-1:0]         job_core_mask_i,
    input  logic                        abort_i,
    output logic [NumCores-1:0]         core_start_o,
    output logic [CfgWidth-1:0]         core_cfg_o,
    input  logic [NumCores-1:0]         core_done_i,
    output logic [NumCores-1:0]         core_abort_o,
    output logic [NumCores-1:0]         core_busy_o,
    output logic                        cpl_valid_o,
    input  logic                        cpl_ready_i,
    output logic [JobIdWidth-1:0]       cpl_id_o,
    output logic [$clog2(NumCores)-1:0] cpl_core_o,
    output logic                        cpl_timeout_o,
    output logic                        idle_o,
    output logic                        err_o
);

    localparam int IdxW = (NumCores > 1) ? $clog2(NumCores) : 1;

    core_state_e           st_q [NumCores];
    core_state_e           st_d [NumCores];
    logic [JobIdWidth-1:0] id_q [NumCores];
    logic [NumCores-1:0]   to_q, to_d;
    cpl_t                  slot_q, slot_d;
    logic                  slot_vld_q, slot_vld_d;
    logic                  err_q, err_d;

    logic [NumCores-1:0] is_idle, is_run, is_done, in_slot, eligible, cpl_req, tmo_hit;
    logic [NumCores-1:0] disp_gnt, cpl_gnt;
    logic [IdxW-1:0]     disp_idx, cpl_idx;
    logic                disp_vld, cpl_vld, fire, accept, slot_load;

    always_comb begin
        for (int c = 0; c < NumCores; c++) begin
            is_idle[c] = (st_q[c] == IDLE);
            is_run[c]  = (st_q[c] == RUN);
            is_done[c] = (st_q[c] == DONE);
            in_slot[c] = slot_vld_q && (slot_q.core == CoreIdxW'(c));
        end
    end

    assign eligible  = is_idle & job_core_mask_i;
    assign accept    = slot_vld_q & cpl_ready_i;
    // The record already sitting in the slot must not be loaded a second time.
    assign cpl_req   = is_done & ~in_slot;
    assign slot_load = (!slot_vld_q || accept) && cpl_vld && !abort_i;

    ising_sched_rr_arb #(.N(NumCores), .IdxW(IdxW)) u_disp_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (eligible),
        .en_i   (fire),
        .gnt_o  (disp_gnt),
        .idx_o  (disp_idx),
        .vld_o  (disp_vld)
    );

    ising_sched_rr_arb #(.N(NumCores), .IdxW(IdxW)) u_cpl_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (cpl_req),
        .en_i   (slot_load),
        .gnt_o  (cpl_gnt),
        .idx_o  (cpl_idx),
        .vld_o  (cpl_vld)
    );

    assign job_ready_o  = disp_vld & !abort_i;
    assign fire         = job_valid_i & job_ready_o;
    assign core_start_o = fire ? disp_gnt : '0;
    assign core_cfg_o   = fire ? job_cfg_i : '0;

`ifdef LAGD_SCHED_TIMEOUT_EN
    logic [15:0] cnt_q [NumCores];

    always_comb begin
        for (int c = 0; c < NumCores; c++) begin
            tmo_hit[c] = is_run[c] && (cnt_q[c] == 16'(TimeoutCycles - 1))
                         && !core_done_i[c] && !abort_i;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumCores; c++) begin
            if (!rst_ni || core_start_o[c]) begin
                cnt_q[c] <= '0;
            end else if (is_run[c]) begin
                cnt_q[c] <= cnt_q[c] + 16'd1;
            end
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TimeoutCycles != 0);
    assign tmo_hit    = '0;
`endif

    assign core_abort_o = tmo_hit;

    always_comb begin
        err_d = err_q;
        to_d  = to_q;
        for (int c = 0; c < NumCores; c++) begin
            st_d[c] = st_q[c];
            unique case (st_q[c])
                IDLE: if (core_start_o[c]) st_d[c] = RUN;
                RUN: begin
                    if (core_done_i[c] || tmo_hit[c]) begin
                        st_d[c] = DONE;
                        to_d[c] = tmo_hit[c];
                    end
                end
                DONE: if (accept && in_slot[c]) st_d[c] = IDLE;
                default: st_d[c] = IDLE;
            endcase
            if (core_done_i[c] && !is_run[c]) err_d = 1'b1;
            if (abort_i) st_d[c] = IDLE;
        end
        // Abort drops any done pulse arriving alongside it, stray or not.
        if (abort_i) err_d = err_q;
    end

    always_comb begin
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q & !accept;
        if (slot_load) begin
            slot_vld_d     = 1'b1;
            slot_d.id      = id_q[cpl_idx];
            slot_d.core    = cpl_idx;
            slot_d.timeout = to_q[cpl_idx];
        end
        if (abort_i) begin
            slot_vld_d = 1'b0;
            slot_d     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            err_q      <= 1'b0;
            to_q       <= '0;
            for (int c = 0; c < NumCores; c++) begin
                st_q[c] <= IDLE;
                id_q[c] <= '0;
            end
        end else begin
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            err_q      <= err_d;
            to_q       <= to_d;
            for (int c = 0; c < NumCores; c++) begin
                st_q[c] <= st_d[c];
                if (core_start_o[c]) id_q[c] <= job_id_i;
            end
        end
    end

    assign core_busy_o   = ~is_idle;
    assign cpl_valid_o   = slot_vld_q;
    assign cpl_id_o      = slot_q.id;
    assign cpl_core_o    = slot_q.core;
    assign cpl_timeout_o = slot_q.timeout;
    assign idle_o        = (&is_idle) & !slot_vld_q;
    assign err_o         = err_q;

    logic [NumCores-1:0] unused_cpl_gnt;
    assign unused_cpl_gnt = cpl_gnt;

endmodule

// File: tb/tb_ising_job_scheduler.sv
// Directed bench for ising_job_scheduler with four cores; the timeout scenario
// runs only when LAGD_SCHED_TIMEOUT_EN is defined (TimeoutCycles = 100 then).
module tb_ising_job_scheduler;

`ifdef LAGD_SCHED_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid, job_ready, abort, cpl_ready, cpl_valid, cpl_timeout, idle, err;
    logic [7:0]  job_id, cpl_id;
    logic [31:0] job_cfg, core_cfg;
    logic [3:0]  mask, core_start, core_done, core_abort, core_busy;
    logic [1:0]  cpl_core;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ising_job_scheduler #(
        .NumCores(4), .JobIdWidth(8), .CfgWidth(32), .TimeoutCycles(TMO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .job_valid_i     (job_valid),
        .job_ready_o     (job_ready),
        .job_id_i        (job_id),
        .job_cfg_i       (job_cfg),
        .job_core_mask_i (mask),
        .abort_i         (abort),
        .core_start_o    (core_start),
        .core_cfg_o      (core_cfg),
        .core_done_i     (core_done),
        .core_abort_o    (core_abort),
        .core_busy_o     (core_busy),
        .cpl_valid_o     (cpl_valid),
        .cpl_ready_i     (cpl_ready),
        .cpl_id_o        (cpl_id),
        .cpl_core_o      (cpl_core),
        .cpl_timeout_o   (cpl_timeout),
        .idle_o          (idle),
        .err_o           (err)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; job_valid = 0; job_id = 0; job_cfg = 0; mask = 0;
        abort = 0; core_done = 0; cpl_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    // Issue four jobs on cores 0..3 in consecutive cycles (fresh pointers assumed).
    task automatic fill_four(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            job_valid = 1; job_id = base + 8'(i); job_cfg = 32'(i); mask = 4'hF;
            #1;
            n_chk++;
            if (core_start !== (4'b0001 << i)) begin
                n_fail++;
                $display("FAIL fill_start%0d: got %b want %b", i, core_start, 4'b0001 << i);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; job_valid = 0; job_id = 0; job_cfg = 0; mask = 0;
        abort = 0; core_done = 0; cpl_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({job_ready, core_start, core_cfg, core_abort, core_busy} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_core_outs: got %b %b %h %b %b want all zero",
                     job_ready, core_start, core_cfg, core_abort, core_busy);
        end
        n_chk++;
        if ({cpl_valid, cpl_id, cpl_core, cpl_timeout, idle, err} !== 14'b0_00000000_00_0_1_0) begin
            n_fail++;
            $display("FAIL reset_cpl_outs: got v=%b id=%h core=%0d to=%b idle=%b err=%b want 0 00 0 0 1 0",
                     cpl_valid, cpl_id, cpl_core, cpl_timeout, idle, err);
        end
        rst_n = 1;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        job_valid = 1; job_id = 8'h11; job_cfg = 32'hDEADBEEF; mask = 4'b0001;
        #1;
        n_chk++;
        if ({job_ready, core_start, core_cfg} !== {1'b1, 4'b0001, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL single_start: got rdy=%b start=%b cfg=%h want 1 0001 deadbeef",
                     job_ready, core_start, core_cfg);
        end
        @(negedge clk);
        job_valid = 0; mask = 0;
        #1;
        n_chk++;
        if ({core_start, core_cfg, core_busy, idle} !== {4'b0, 32'h0, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL single_run: got start=%b cfg=%h busy=%b idle=%b want 0000 0 0001 0",
                     core_start, core_cfg, core_busy, idle);
        end
        core_done = 4'b0001;
        @(negedge clk);
        core_done = 0;
        #1;
        n_chk++;
        if (cpl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cpl_early: got %b want 0", cpl_valid);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({cpl_valid, cpl_id, cpl_core, cpl_timeout} !== {1'b1, 8'h11, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_cpl: got v=%b id=%h core=%0d to=%b want 1 11 0 0",
                     cpl_valid, cpl_id, cpl_core, cpl_timeout);
        end
        cpl_ready = 1;
        @(negedge clk);
        cpl_ready = 0;
        #1;
        n_chk++;
        if ({cpl_valid, core_busy, idle, err} !== {1'b0, 4'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b busy=%b idle=%b err=%b want 0 0000 1 0",
                     cpl_valid, core_busy, idle, err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill_four(8'h20);
        @(negedge clk);
        job_id = 8'h24;
        #1;
        n_chk++;
        if ({job_ready, core_start, core_busy} !== {1'b0, 4'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL b2b_fifth_stall: got rdy=%b start=%b busy=%b want 0 0000 1111",
                     job_ready, core_start, core_busy);
        end
        core_done = 4'b0100;
        @(negedge clk);
        core_done = 0;
        #1;
        n_chk++;
        if (job_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_state_stall: got %b want 0", job_ready);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({cpl_valid, cpl_id, cpl_core, job_ready} !== {1'b1, 8'h22, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_cpl: got v=%b id=%h core=%0d rdy=%b want 1 22 2 0",
                     cpl_valid, cpl_id, cpl_core, job_ready);
        end
        cpl_ready = 1;
        @(negedge clk);
        cpl_ready = 0;
        #1;
        n_chk++;
        if ({core_busy, job_ready, core_start} !== {4'b1011, 1'b1, 4'b0100}) begin
            n_fail++;
            $display("FAIL b2b_redispatch: got busy=%b rdy=%b start=%b want 1011 1 0100",
                     core_busy, job_ready, core_start);
        end
        @(negedge clk);
        job_valid = 0;
    endtask

    task automatic test_simul_done();
        do_reset();
        fill_four(8'h30);
        @(negedge clk);
        job_valid = 0; cpl_ready = 1; core_done = 4'b1010;
        @(negedge clk);
        core_done = 0;
        #1;
        n_chk++;
        if (cpl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_early: got %b want 0", cpl_valid);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({cpl_valid, cpl_id, cpl_core} !== {1'b1, 8'h31, 2'd1}) begin
            n_fail++;
            $display("FAIL simul_first: got v=%b id=%h core=%0d want 1 31 1", cpl_valid, cpl_id, cpl_core);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({cpl_valid, cpl_id, cpl_core, core_busy} !== {1'b1, 8'h33, 2'd3, 4'b1101}) begin
            n_fail++;
            $display("FAIL simul_second: got v=%b id=%h core=%0d busy=%b want 1 33 3 1101",
                     cpl_valid, cpl_id, cpl_core, core_busy);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({cpl_valid, core_busy} !== {1'b0, 4'b0101}) begin
            n_fail++;
            $display("FAIL simul_empty: got v=%b busy=%b want 0 0101", cpl_valid, core_busy);
        end
        cpl_ready = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        job_valid = 1; job_id = 8'h40; job_cfg = 32'h1; mask = 4'b0001;
        @(negedge clk);
        job_valid = 0; core_done = 4'b0001;
        @(negedge clk);
        core_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            job_valid = 1; job_id = 8'h41; mask = 4'b0001;
            #1;
            n_chk++;
            if ({cpl_valid, cpl_id, cpl_core, cpl_timeout, core_busy[0], job_ready, core_start, core_abort}
                !== {1'b1, 8'h40, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0, 4'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b id=%h core=%0d to=%b busy0=%b rdy=%b start=%b abort=%b",
                         k, cpl_valid, cpl_id, cpl_core, cpl_timeout, core_busy[0], job_ready,
                         core_start, core_abort);
            end
        end
        cpl_ready = 1;
        @(negedge clk);
        cpl_ready = 0;
        #1;
        n_chk++;
        if ({cpl_valid, job_ready, core_start} !== {1'b0, 1'b1, 4'b0001}) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b rdy=%b start=%b want 0 1 0001", cpl_valid, job_ready, core_start);
        end
        @(negedge clk);
        job_valid = 0;
    endtask

    task automatic test_abort();
        do_reset();
        fill_four(8'h50);
        @(negedge clk);
        job_valid = 0; core_done = 4'b1000;
        @(negedge clk);
        core_done = 0;
        @(negedge clk);
        #1;
        n_chk++;
        if ({cpl_valid, cpl_core, core_busy} !== {1'b1, 2'd3, 4'hF}) begin
            n_fail++;
            $display("FAIL abort_setup: got v=%b core=%0d busy=%b want 1 3 1111", cpl_valid, cpl_core, core_busy);
        end
        @(negedge clk);
        abort = 1; job_valid = 1; job_id = 8'h5F; mask = 4'hF; core_done = 4'b0001;
        #1;
        n_chk++;
        if ({job_ready, core_start} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_no_start: got rdy=%b start=%b want 0 0000", job_ready, core_start);
        end
        @(negedge clk);
        abort = 0; job_valid = 0; core_done = 0;
        #1;
        n_chk++;
        if ({core_busy, cpl_valid, idle, err} !== {4'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_flush: got busy=%b v=%b idle=%b err=%b want 0000 0 1 0",
                     core_busy, cpl_valid, idle, err);
        end
        core_done = 4'b0010;
        @(negedge clk);
        core_done = 0;
        #1;
        n_chk++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_stray_done_err: got %b want 1", err);
        end
        repeat (3) @(negedge clk);
        job_valid = 1; mask = 4'b0000;
        #1;
        n_chk++;
        if ({job_ready, core_start, err} !== {1'b0, 4'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_mask: got rdy=%b start=%b err=%b want 0 0000 1", job_ready, core_start, err);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({idle, core_busy} !== {1'b1, 4'b0}) begin
            n_fail++;
            $display("FAIL zero_mask_idle: got idle=%b busy=%b want 1 0000", idle, core_busy);
        end
        job_valid = 0;
        do_reset();
        #1;
        n_chk++;
        if ({err, idle} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_clears_err: got err=%b idle=%b want 0 1", err, idle);
        end
    endtask

`ifdef LAGD_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int first_pulse;
        int pulses;
        first_pulse = -1;
        pulses = 0;
        do_reset();
        @(negedge clk);
        job_valid = 1; job_id = 8'h60; job_cfg = 32'h2; mask = 4'b0001;
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            job_valid = 0;
            #1;
            if (core_abort != 4'b0) begin
                pulses++;
                if (first_pulse < 0) first_pulse = k;
            end
        end
        n_chk++;
        if (first_pulse != 100 || pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_pulse: got first=%0d count=%0d want 100 1", first_pulse, pulses);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({cpl_valid, cpl_id, cpl_core, cpl_timeout} !== {1'b1, 8'h60, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_cpl: got v=%b id=%h core=%0d to=%b want 1 60 0 1",
                     cpl_valid, cpl_id, cpl_core, cpl_timeout);
        end
    endtask
`endif

    initial begin
        rst_n = 0; job_valid = 0; job_id = 0; job_cfg = 0; mask = 0;
        abort = 0; core_done = 0; cpl_ready = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_simul_done();
        test_backpressure();
        test_abort();
`ifdef LAGD_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
